// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline skid register: state encodings and default width.
// State is {out_valid, skid_valid}, so the encoding doubles as the handshake outputs.
package pipe_pkg;

   localparam int PIPE_W = 32;

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'b00,
      ST_ILLEGAL = 2'b01,
      ST_BUSY    = 2'b10,
      ST_FULL    = 2'b11
   } pipe_state_e;

endpackage

// File: rtl/pipe_data_reg.sv
// WIDTH-bit load-enable register with async active-high reset to RESET_VAL.
// The load source is either the upstream payload or the skid entry.
module pipe_data_reg
   import pipe_pkg::*;
#(
   parameter int               WIDTH     = PIPE_W,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             sel_skid_i,
   input  logic [WIDTH-1:0] in_data_i,
   input  logic [WIDTH-1:0] skid_data_i,
   output logic [WIDTH-1:0] data_o
);

   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;

   assign data_d = sel_skid_i ? skid_data_i : in_data_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= RESET_VAL;
      end else if (load_i) begin
         data_q <= data_d;
      end
   end

   assign data_o = data_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer and sync flush.
// Optional stall counter output enabled by defining PIPE_STALL_CNT_EN.
module pipe_skid_reg
   import pipe_pkg::*;
#(
   parameter int               WIDTH     = PIPE_W,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
`ifdef PIPE_STALL_CNT_EN
   ,
   output logic [31:0]      stall_cnt
`endif
);

   pipe_state_e      state_q;
   pipe_state_e      state_d;
   logic             accept;
   logic             drain;
   logic             main_load;
   logic             main_sel_skid;
   logic             skid_load;
   logic [WIDTH-1:0] skid_data;

   // Handshake outputs come straight from the state flops; out_ready never reaches in_ready.
   assign out_valid = state_q[1];
   assign in_ready  = ~state_q[0];

   assign accept = in_valid & in_ready;
   assign drain  = out_valid & out_ready;

   assign main_load = ~flush & (((state_q == ST_EMPTY) & accept) |
                                ((state_q == ST_BUSY) & accept & drain) |
                                ((state_q == ST_FULL) & drain));
   assign main_sel_skid = (state_q == ST_FULL);
   assign skid_load     = ~flush & (state_q == ST_BUSY) & accept & ~drain;

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: if (accept) state_d = ST_BUSY;
            ST_BUSY: begin
               if (accept & ~drain)      state_d = ST_FULL;
               else if (~accept & drain) state_d = ST_EMPTY;
            end
            ST_FULL:  if (drain) state_d = ST_BUSY;
            default:  state_d = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   pipe_data_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
      .clk         (clk),
      .rst         (rst),
      .load_i      (main_load),
      .sel_skid_i  (main_sel_skid),
      .in_data_i   (in_data),
      .skid_data_i (skid_data),
      .data_o      (out_data)
   );

   pipe_data_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
      .clk         (clk),
      .rst         (rst),
      .load_i      (skid_load),
      .sel_skid_i  (1'b0),
      .in_data_i   (in_data),
      .skid_data_i (in_data),
      .data_o      (skid_data)
   );

`ifdef PIPE_STALL_CNT_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] stall_cnt_d;

   // Saturating count of cycles where the held entry is blocked downstream.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (out_valid & ~out_ready & ~flush & (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= 32'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: directed steps push accepted payloads, a monitor pops on drain.
// Covers the PIPE_STALL_CNT_EN counter when that macro is defined.
module tb_pipe_skid_reg;

   localparam int W = 32;

   logic         clk;
   logic         rst;
   logic         flush;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
`ifdef PIPE_STALL_CNT_EN
   logic [31:0]  stall_cnt;
`endif

   logic [W-1:0] exp_q[$];
   int           occ;
   int           checks;
   int           errors;

   pipe_skid_reg #(.WIDTH(W), .RESET_VAL({W{1'b0}})) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
`ifdef PIPE_STALL_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One handshake cycle: drive, check model handshake at negedge, update model, return at posedge+1.
   task automatic step(input logic v, input logic [W-1:0] d, input logic ord, input logic fl);
      logic acc;
      logic drn;
      in_valid  = v;
      in_data   = d;
      out_ready = ord;
      flush     = fl;
      @(negedge clk);
      chk("in_ready", 32'(in_ready), 32'(occ < 2));
      chk("out_valid", 32'(out_valid), 32'(occ > 0));
      if (occ > 0 && !ord) chk("hold_data", out_data, exp_q[0]);
      if (fl) begin
         occ = 0;
         exp_q.delete();
      end else begin
         acc = v && (occ < 2);
         drn = (occ > 0) && ord;
         if (acc) exp_q.push_back(d);
         occ = occ + int'(acc) - int'(drn);
      end
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready && !flush) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL drain_unexpected got %h expected none at %0t", out_data, $time);
         end else begin
            chk("drain_data", out_data, exp_q.pop_front());
         end
      end
   end

   initial begin
      checks    = 0;
      errors    = 0;
      occ       = 0;
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'hDEAD_BEEF;
      out_ready = 1'b0;

      @(negedge clk);
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_data", out_data, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // First accept after reset appears one cycle later.
      step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0);

      for (int i = 1; i <= 16; i++) step(1'b1, W'(i), 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0);

      // Skid fill, ignored input while full, then in-order drain.
      step(1'b1, 32'hA, 1'b0, 1'b0);
      step(1'b1, 32'hB, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b1, 32'h99, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0);

      // Flush while full with a competing accept.
      step(1'b1, 32'hA, 1'b0, 1'b0);
      step(1'b1, 32'hB, 1'b0, 1'b0);
      step(1'b1, 32'hC, 1'b1, 1'b1);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0);

      // Asynchronous reset between edges while full.
      step(1'b1, 32'hD, 1'b0, 1'b0);
      step(1'b1, 32'hE, 1'b0, 1'b0);
      in_valid = 1'b0;
      #1 rst = 1'b1;
      #1 rst = 1'b0;
      #1;
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_in_ready", 32'(in_ready), 32'd1);
      chk("arst_out_data", out_data, 32'd0);
      occ = 0;
      exp_q.delete();
      @(posedge clk);
      #1;

`ifdef PIPE_STALL_CNT_EN
      step(1'b1, 32'h11, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b1);
      chk("stall_cnt_5", stall_cnt, 32'd5);
      step(1'b1, 32'h12, 1'b0, 1'b0);
      force dut.stall_cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.stall_cnt_q;
      for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
      chk("stall_cnt_sat", stall_cnt, 32'hFFFF_FFFF);
      step(1'b0, 32'h0, 1'b0, 1'b1);
`endif

      step(1'b1, 32'h1234_5678, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
